// File: rtl/time_keeper_bcd.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper_bcd
// Description : 24-hour BCD time-of-day keeper. A prescaler divides clk down
//               to a one-second tick that advances HH:MM:SS in BCD. With run
//               low, edge-detected buttons set hours, minutes and clear the
//               seconds.
// Ports       : clk                 system clock, rising edge
//               reset               asynchronous active-high reset
//               run                 1 = counting, 0 = set mode
//               inc_hour            button, rising edge = hour + 1 (mod 24)
//               inc_min             button, rising edge = minute + 1 (mod 60)
//               clr_sec             button, rising edge = seconds := 00
//               hourMSB .. secLSB   registered BCD digits
//               sec_tick            one-cycle pulse when a tick update shows
// Revision    : 1.0 - initial release
// ============================================================================
module time_keeper_bcd #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       clr_sec,
    output logic [3:0] hourMSB,
    output logic [3:0] hourLSB,
    output logic [3:0] minMSB,
    output logic [3:0] minLSB,
    output logic [3:0] secMSB,
    output logic [3:0] secLSB,
    output logic       sec_tick
);

    localparam int unsigned      c_PW   = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0]  c_LAST = c_PW'(TICK_DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic            r_hour_q, r_min_q, r_clr_q;
    logic [3:0]      r_hour_msb, r_hour_lsb, r_min_msb, r_min_lsb;
    logic [3:0]      r_sec_msb, r_sec_lsb;
    logic            r_sec_tick;

    logic            w_tick;
    logic            w_hour_req, w_min_req, w_clr_req;
    logic [3:0]      w_hour_msb, w_hour_lsb, w_min_msb, w_min_lsb;
    logic [3:0]      w_sec_msb, w_sec_lsb;

    // Two-digit BCD increment wrapping 59 -> 00.
    function automatic logic [7:0] f_inc60(input logic [3:0] msb, input logic [3:0] lsb);
        if (lsb == 4'd9)
            return {((msb == 4'd5) ? 4'd0 : msb + 4'd1), 4'd0};
        else
            return {msb, lsb + 4'd1};
    endfunction

    // Two-digit BCD increment wrapping 23 -> 00.
    function automatic logic [7:0] f_inc24(input logic [3:0] msb, input logic [3:0] lsb);
        if (msb == 4'd2 && lsb == 4'd3)
            return 8'h00;
        else if (lsb == 4'd9)
            return {msb + 4'd1, 4'd0};
        else
            return {msb, lsb + 4'd1};
    endfunction

    // run gates the tick, so dropping run on the terminal count suppresses it.
    assign w_tick = run && (r_presc == c_LAST);

    // Requests are formed regardless of run; the update logic discards them
    // while counting so nothing is queued for later.
    assign w_hour_req = inc_hour & ~r_hour_q;
    assign w_min_req  = inc_min  & ~r_min_q;
    assign w_clr_req  = clr_sec  & ~r_clr_q;

    always_comb begin
        w_hour_msb = r_hour_msb;
        w_hour_lsb = r_hour_lsb;
        w_min_msb  = r_min_msb;
        w_min_lsb  = r_min_lsb;
        w_sec_msb  = r_sec_msb;
        w_sec_lsb  = r_sec_lsb;
        if (w_tick) begin
            {w_sec_msb, w_sec_lsb} = f_inc60(r_sec_msb, r_sec_lsb);
            if (r_sec_msb == 4'd5 && r_sec_lsb == 4'd9) begin
                {w_min_msb, w_min_lsb} = f_inc60(r_min_msb, r_min_lsb);
                if (r_min_msb == 4'd5 && r_min_lsb == 4'd9)
                    {w_hour_msb, w_hour_lsb} = f_inc24(r_hour_msb, r_hour_lsb);
            end
        end else if (!run) begin
            // Set mode: each request touches only its own field.
            if (w_hour_req)
                {w_hour_msb, w_hour_lsb} = f_inc24(r_hour_msb, r_hour_lsb);
            if (w_min_req)
                {w_min_msb, w_min_lsb} = f_inc60(r_min_msb, r_min_lsb);
            if (w_clr_req) begin
                w_sec_msb = 4'd0;
                w_sec_lsb = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_hour_q   <= 1'b0;
            r_min_q    <= 1'b0;
            r_clr_q    <= 1'b0;
            r_hour_msb <= 4'd0;
            r_hour_lsb <= 4'd0;
            r_min_msb  <= 4'd0;
            r_min_lsb  <= 4'd0;
            r_sec_msb  <= 4'd0;
            r_sec_lsb  <= 4'd0;
            r_sec_tick <= 1'b0;
        end else begin
            // Held at zero in set mode so the first tick lands TICK_DIV
            // cycles after run rises.
            if (!run || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;
            r_hour_q   <= inc_hour;
            r_min_q    <= inc_min;
            r_clr_q    <= clr_sec;
            r_hour_msb <= w_hour_msb;
            r_hour_lsb <= w_hour_lsb;
            r_min_msb  <= w_min_msb;
            r_min_lsb  <= w_min_lsb;
            r_sec_msb  <= w_sec_msb;
            r_sec_lsb  <= w_sec_lsb;
            r_sec_tick <= w_tick;
        end
    end

    assign hourMSB  = r_hour_msb;
    assign hourLSB  = r_hour_lsb;
    assign minMSB   = r_min_msb;
    assign minLSB   = r_min_lsb;
    assign secMSB   = r_sec_msb;
    assign secLSB   = r_sec_lsb;
    assign sec_tick = r_sec_tick;

endmodule
`default_nettype wire
